// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
//
// Purpose:
//   - EX-stage operand forwarding selects (MEM result has priority over WB).
//   - Load-use detection: one bubble into ID/EX, with PC and IF/ID held.
//   - Taken-branch flush of IF/ID and ID/EX.
//   - RUN / MEM_WAIT FSM that freezes the pipeline while data memory is busy,
//     with an optional timeout that raises a sticky error.
//   - Saturating counters of stall cycles and branch-flush cycles.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rs1_de, rs2_de              decode-stage source registers
//   rs1_ex, rs2_ex              EX-stage source registers
//   RD_ex, RUWr_ex,
//   RUDataWrSrc_ex              EX-stage destination, write enable, writeback source
//   RD_me, RUWr_me              MEM-stage destination and write enable
//   RD_wb, RUWr_wb              WB-stage destination and write enable
//   BrTaken_ex                  branch/jump in EX resolved taken
//   dm_req_me, dm_ready         data memory request from MEM / memory completes
//   StallF..StallM              hold PC, IF/ID, ID/EX, EX/MEM
//   ClrD, Clr1, Clr2            IF/ID flush, load-use bubble, branch flush of ID/EX
//   FwdA_ex, FwdB_ex            00 regfile, 01 WB value, 10 MEM value
//   stall_cnt, flush_cnt        saturating performance counters
//   mem_err                     sticky memory-wait timeout flag
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_de,
   input  logic [4:0]       rs2_de,
   input  logic [4:0]       rs1_ex,
   input  logic [4:0]       rs2_ex,
   input  logic [4:0]       RD_ex,
   input  logic             RUWr_ex,
   input  logic [1:0]       RUDataWrSrc_ex,
   input  logic [4:0]       RD_me,
   input  logic             RUWr_me,
   input  logic [4:0]       RD_wb,
   input  logic             RUWr_wb,
   input  logic             BrTaken_ex,
   input  logic             dm_req_me,
   input  logic             dm_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             ClrD,
   output logic             Clr1,
   output logic             Clr2,
   output logic [1:0]       FwdA_ex,
   output logic [1:0]       FwdB_ex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_err
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic              load_use;

   always_comb begin
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      StallM      = 1'b0;
      ClrD        = 1'b0;
      Clr1        = 1'b0;
      Clr2        = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;

      if (RUWr_me && RD_me != 5'd0 && RD_me == rs1_ex)      FwdA_ex = 2'b10;
      else if (RUWr_wb && RD_wb != 5'd0 && RD_wb == rs1_ex) FwdA_ex = 2'b01;
      else                                                   FwdA_ex = 2'b00;

      if (RUWr_me && RD_me != 5'd0 && RD_me == rs2_ex)      FwdB_ex = 2'b10;
      else if (RUWr_wb && RD_wb != 5'd0 && RD_wb == rs2_ex) FwdB_ex = 2'b01;
      else                                                   FwdB_ex = 2'b00;

      load_use = RUWr_ex && (RUDataWrSrc_ex == 2'b01) && (RD_ex != 5'd0) &&
                 ((RD_ex == rs1_de) || (RD_ex == rs2_de));

      case (state_q)
         ST_RUN: begin
            if (dm_req_me && !dm_ready) begin
               {StallF, StallD, StallE, StallM} = 4'b1111;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else if (BrTaken_ex) begin
               // Decode holds a wrong-path instruction, so the flush beats load-use.
               ClrD = 1'b1;
               Clr2 = 1'b1;
            end else if (load_use) begin
               StallF = 1'b1;
               StallD = 1'b1;
               Clr1   = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dm_ready) begin
               // Release cycle: the frozen instructions see normal RUN rules now.
               state_d    = ST_RUN;
               wait_cnt_d = '0;
               if (BrTaken_ex) begin
                  ClrD = 1'b1;
                  Clr2 = 1'b1;
               end else if (load_use) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  Clr1   = 1'b1;
               end
            end else begin
               {StallF, StallD, StallE, StallM} = 4'b1111;
               if (MEM_TIMEOUT != 0 && wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                  state_d    = ST_RUN;
                  wait_cnt_d = '0;
                  mem_err_d  = 1'b1;
               end else if (wait_cnt_q != '1) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase

      // Reset forces a bubble into the front of the pipe regardless of state.
      if (rst) begin
         {StallF, StallD, StallE, StallM} = 4'b0000;
         ClrD    = 1'b1;
         Clr1    = 1'b1;
         Clr2    = 1'b0;
         FwdA_ex = 2'b00;
         FwdB_ex = 2'b00;
      end

      stall_cnt_d = (StallF && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (Clr2 && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int CW   = 6;
   localparam int TO   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk, rst;
   logic [4:0]    rs1_de, rs2_de, rs1_ex, rs2_ex, RD_ex, RD_me, RD_wb;
   logic          RUWr_ex, RUWr_me, RUWr_wb, BrTaken_ex, dm_req_me, dm_ready;
   logic [1:0]    RUDataWrSrc_ex;
   logic          StallF, StallD, StallE, StallM, ClrD, Clr1, Clr2, mem_err;
   logic [1:0]    FwdA_ex, FwdB_ex;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
      .RD_ex(RD_ex), .RUWr_ex(RUWr_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex),
      .RD_me(RD_me), .RUWr_me(RUWr_me), .RD_wb(RD_wb), .RUWr_wb(RUWr_wb),
      .BrTaken_ex(BrTaken_ex), .dm_req_me(dm_req_me), .dm_ready(dm_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .ClrD(ClrD), .Clr1(Clr1), .Clr2(Clr2),
      .FwdA_ex(FwdA_ex), .FwdB_ex(FwdB_ex),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: "waiting" flag plus how many wait cycles have elapsed.
   bit m_wait;
   int m_waited, m_stall, m_flush;
   bit m_err;
   logic [6:0] exp_ctrl; // {StallF,StallD,StallE,StallM,ClrD,Clr1,Clr2}

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (RUWr_me && RD_me != 0 && RD_me == rs) return 2'b10;
      if (RUWr_wb && RD_wb != 0 && RD_wb == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
   endtask

   task automatic check_comb();
      logic lu;
      logic [1:0] efa, efb;
      lu  = RUWr_ex && RUDataWrSrc_ex == 2'b01 && RD_ex != 0 &&
            (RD_ex == rs1_de || RD_ex == rs2_de);
      efa = fwd_ref(rs1_ex);
      efb = fwd_ref(rs2_ex);
      if (rst) begin
         exp_ctrl = 7'b0000110; efa = 2'b00; efb = 2'b00;
      end else if (dm_req_me && !dm_ready && !m_wait) exp_ctrl = 7'b1111000;
      else if (m_wait && !dm_ready)                   exp_ctrl = 7'b1111000;
      else if (BrTaken_ex)                            exp_ctrl = 7'b0000101;
      else if (lu)                                    exp_ctrl = 7'b1100010;
      else                                            exp_ctrl = 7'b0000000;
      check_eq("ctrl", {StallF, StallD, StallE, StallM, ClrD, Clr1, Clr2}, exp_ctrl);
      check_eq("fwdA", FwdA_ex, efa);
      check_eq("fwdB", FwdB_ex, efb);
   endtask

   task automatic check_regs();
      check_eq("stall_cnt", stall_cnt, m_stall);
      check_eq("flush_cnt", flush_cnt, m_flush);
      check_eq("mem_err", mem_err, m_err);
   endtask

   task automatic model_step();
      if (exp_ctrl[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (exp_ctrl[0]) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (!m_wait) begin
         if (dm_req_me && !dm_ready) begin
            m_wait = 1; m_waited = 1;
         end
      end else if (dm_ready) begin
         m_wait = 0; m_waited = 0;
      end else if (TO != 0 && m_waited == TO) begin
         m_wait = 0; m_waited = 0; m_err = 1;
      end else begin
         m_waited++;
      end
   endtask

   // Inputs are set just after a posedge; check combinational outputs, clock, check state.
   task automatic cycle();
      #1;
      check_comb();
      model_step();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic clear_inputs();
      {rs1_de, rs2_de, rs1_ex, rs2_ex, RD_ex, RD_me, RD_wb} = '0;
      {RUWr_ex, RUWr_me, RUWr_wb, BrTaken_ex, dm_req_me} = '0;
      RUDataWrSrc_ex = 2'b00;
      dm_ready = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_comb();
      check_regs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      model_reset();
      #1;
      check_comb();
      check_eq("rst_clr", {ClrD, Clr1, Clr2}, 3'b110);
      check_regs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Forwarding priority
      RD_me = 5; RUWr_me = 1; RD_wb = 5; RUWr_wb = 1; rs1_ex = 5; rs2_ex = 0;
      #1; check_eq("fwd_mem", {FwdA_ex, FwdB_ex}, 4'b1000);
      cycle();
      RUWr_me = 0;
      #1; check_eq("fwd_wb", FwdA_ex, 2'b01);
      cycle();
      RD_me = 0; RD_wb = 0; RUWr_me = 1;
      #1; check_eq("fwd_x0", FwdA_ex, 2'b00);
      cycle();
      clear_inputs();

      // Load-use: one bubble
      RD_ex = 7; RUWr_ex = 1; RUDataWrSrc_ex = 2'b01; rs2_de = 7;
      #1; check_eq("lu_ctrl", {StallF, StallD, StallE, Clr1}, 4'b1101);
      cycle();
      check_eq("lu_cnt", stall_cnt, 1);
      RUWr_ex = 0; rs2_de = 0;
      #1; check_eq("lu_after", {StallF, StallD, Clr1}, 3'b000);
      cycle();

      // Branch beats load-use
      RD_ex = 7; RUWr_ex = 1; RUDataWrSrc_ex = 2'b01; rs1_de = 7; BrTaken_ex = 1;
      #1; check_eq("br_lu", {ClrD, Clr2, Clr1, StallF}, 4'b1100);
      cycle();
      check_eq("br_cnt", flush_cnt, 1);
      clear_inputs();

      // Memory wait: three stalled cycles then release
      dm_req_me = 1; dm_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1; check_eq("mw_stall", {StallF, StallD, StallE, StallM}, 4'b1111);
         cycle();
      end
      dm_ready = 1;
      #1; check_eq("mw_release", {StallF, StallD, StallE, StallM}, 4'b0000);
      cycle();
      check_eq("mw_cnt", stall_cnt, 4);
      check_eq("mw_err", mem_err, 1'b0);
      clear_inputs();

      // Timeout: RUN entry cycle plus wait counts 1..4
      dm_req_me = 1; dm_ready = 0;
      for (int i = 0; i < 5; i++) cycle();
      dm_req_me = 0;
      #1; check_eq("to_exit", {StallF, StallM}, 2'b00);
      check_eq("to_err", mem_err, 1'b1);
      cycle();
      cycle();
      check_eq("to_sticky", mem_err, 1'b1);
      clear_inputs();

      // Async reset while frozen in MEM_WAIT
      dm_req_me = 1; dm_ready = 0;
      cycle();
      cycle();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_eq("arst_ctrl", {StallF, StallD, StallE, StallM, ClrD, Clr1}, 6'b000011);
      check_eq("arst_cnt", {stall_cnt, flush_cnt, mem_err}, '0);
      @(negedge clk);
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("arst_run", StallF, 1'b0);

      // Saturation of both counters
      dm_req_me = 1; dm_ready = 0;
      for (int i = 0; i < 70; i++) cycle();
      check_eq("sat_stall", stall_cnt, CMAX);
      clear_inputs();
      BrTaken_ex = 1;
      for (int i = 0; i < 70; i++) cycle();
      check_eq("sat_flush", flush_cnt, CMAX);
      clear_inputs();
      apply_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rs1_de = 5'($urandom_range(0, 3)); rs2_de = 5'($urandom_range(0, 3));
         rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
         RD_ex  = 5'($urandom_range(0, 3)); RD_me  = 5'($urandom_range(0, 3));
         RD_wb  = 5'($urandom_range(0, 3));
         RUWr_ex = 1'($urandom); RUWr_me = 1'($urandom); RUWr_wb = 1'($urandom);
         RUDataWrSrc_ex = 2'($urandom_range(0, 3));
         BrTaken_ex = ($urandom_range(0, 7) == 0);
         dm_req_me  = ($urandom_range(0, 2) == 0);
         dm_ready   = ((i / 300) % 2 == 0) ? 1'($urandom) : ($urandom_range(0, 5) == 0);
         cycle();
         if (i == 1500) begin
            clear_inputs();
            apply_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
